// File: rtl/tsb_retry_sched.sv
// tsb_retry_sched: holds NACKed tsb entries for an exponential backoff,
// then issues retry or free requests on the tsb retry port.
module tsb_retry_sched #(
  parameter int LOG_TSB_SIZE = 3,
  parameter int CNT_W = 16,
  parameter int MAX_SHIFT = 6
) (
  input  logic clk,
  input  logic rstn,
  input  logic [7:0] cfg_base_delay,
  input  logic nack_valid,
  input  logic [LOG_TSB_SIZE-1:0] nack_tsb_id,
  input  logic nack_tied,
  input  logic ack_valid,
  input  logic [LOG_TSB_SIZE-1:0] ack_tsb_id,
  input  logic abort_valid,
  input  logic [LOG_TSB_SIZE-1:0] abort_tsb_id,
  output logic retry_valid,
  input  logic retry_ready,
  output logic [LOG_TSB_SIZE-1:0] retry_tsb_id,
  output logic retry_abort,
  output logic retry_tied,
  output logic [LOG_TSB_SIZE:0] n_waiting,
  output logic empty,
  output logic proto_err
);
  localparam int N = 2**LOG_TSB_SIZE;
  localparam int L = LOG_TSB_SIZE;
  localparam int NW = LOG_TSB_SIZE + 1;

  typedef enum logic [1:0] {
    FLIGHT,
    WAIT,
    READY
  } st_t;

  st_t st [N];
  logic [2:0] att [N];
  logic [CNT_W-1:0] cnt [N];
  logic [N-1:0] tied_q, ab_q, pend;
  logic [L-1:0] last;

  logic [7:0] base;
  logic [31:0] d_full;
  logic [CNT_W-1:0] d_sat, cnt_load;
  logic [2:0] att_inc;
  logic [N-1:0] nk, ak, bk, held, rdy, cand;
  logic [L-1:0] pick, idx;
  logic pick_ok, load, hs;
  logic [NW-1:0] nw;

  assign base = (cfg_base_delay == 8'd0) ? 8'd1 : cfg_base_delay;
  assign d_full = 32'(base) << att[nack_tsb_id];
  assign d_sat = (|(d_full >> CNT_W)) ? '1 : d_full[CNT_W-1:0];
  assign cnt_load = d_sat - CNT_W'(1);
  assign att_inc = (att[nack_tsb_id] >= 3'(MAX_SHIFT)) ?
                   3'(MAX_SHIFT) : att[nack_tsb_id] + 3'd1;
  assign hs = retry_valid & retry_ready;
  assign load = ~retry_valid | retry_ready;
  assign empty = (n_waiting == '0) & ~retry_valid;

  always_comb begin
    nk = '0;
    ak = '0;
    bk = '0;
    held = '0;
    rdy = '0;
    nw = '0;
    for (int i = 0; i < N; i++) begin
      nk[i] = nack_valid && (nack_tsb_id == L'(i));
      ak[i] = ack_valid && (ack_tsb_id == L'(i)) && !nk[i];
      bk[i] = abort_valid && (abort_tsb_id == L'(i));
      held[i] = retry_valid && (retry_tsb_id == L'(i));
      rdy[i] = (st[i] == READY) && !held[i];
      if (st[i] != FLIGHT) nw = nw + NW'(1);
    end
  end

  // Abort-class entries win; round-robin starts after the last pick.
  always_comb begin
    cand = (|(rdy & ab_q)) ? (rdy & ab_q) : rdy;
    pick = '0;
    pick_ok = 1'b0;
    idx = '0;
    for (int k = 1; k <= N; k++) begin
      idx = last + L'(k);
      if (!pick_ok && cand[idx]) begin
        pick_ok = 1'b1;
        pick = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) begin
        st[i] <= FLIGHT;
        att[i] <= '0;
        cnt[i] <= '0;
      end
      tied_q <= '0;
      ab_q <= '0;
      pend <= '0;
      last <= L'(N - 1);
      retry_valid <= 1'b0;
      retry_tsb_id <= '0;
      retry_abort <= 1'b0;
      retry_tied <= 1'b0;
      n_waiting <= '0;
      proto_err <= 1'b0;
    end else begin
      n_waiting <= nw;
      if ((nack_valid && st[nack_tsb_id] != FLIGHT) ||
          (ack_valid && st[ack_tsb_id] != FLIGHT))
        proto_err <= 1'b1;
      for (int i = 0; i < N; i++) begin
        unique case (st[i])
          FLIGHT: begin
            if (nk[i]) begin
              cnt[i] <= cnt_load;
              att[i] <= att_inc;
              tied_q[i] <= nack_tied;
              if (pend[i] || bk[i]) begin
                st[i] <= READY;
                ab_q[i] <= 1'b1;
              end else begin
                st[i] <= WAIT;
              end
            end else begin
              if (ak[i]) begin
                att[i] <= '0;
                pend[i] <= 1'b0;
              end
              if (bk[i]) pend[i] <= 1'b1;
            end
          end
          WAIT: begin
            if (bk[i]) begin
              st[i] <= READY;
              ab_q[i] <= 1'b1;
            end else if (cnt[i] == '0) begin
              st[i] <= READY;
              ab_q[i] <= 1'b0;
            end else begin
              cnt[i] <= cnt[i] - CNT_W'(1);
            end
          end
          READY: begin
            if (held[i]) begin
              if (hs) begin
                st[i] <= FLIGHT;
                if (retry_abort) begin
                  att[i] <= '0;
                  pend[i] <= 1'b0;
                end else if (bk[i]) begin
                  pend[i] <= 1'b1;
                end
              end else if (bk[i]) begin
                pend[i] <= 1'b1;
              end
            end else if (bk[i]) begin
              ab_q[i] <= 1'b1;
              // Loaded behind a live request: abort waits for the next NACK.
              if (load && pick_ok && pick == L'(i) && retry_valid)
                pend[i] <= 1'b1;
            end
          end
          default: st[i] <= FLIGHT;
        endcase
      end
      if (load) begin
        if (pick_ok) begin
          retry_valid <= 1'b1;
          retry_tsb_id <= pick;
          retry_abort <= ab_q[pick] | (bk[pick] & ~retry_valid);
          retry_tied <= tied_q[pick];
          last <= pick;
        end else begin
          retry_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_tsb_retry_sched.sv
// tb_tsb_retry_sched: directed scenarios plus random traffic checked
// against a deadline-based reference model of the retry scheduler.
module tb_tsb_retry_sched;
  logic clk = 1'b0;
  logic rstn;
  logic [7:0] cfg_base_delay;
  logic nack_valid, nack_tied, ack_valid, abort_valid, retry_ready;
  logic [2:0] nack_tsb_id, ack_tsb_id, abort_tsb_id;
  logic retry_valid, retry_abort, retry_tied, empty, proto_err;
  logic [2:0] retry_tsb_id;
  logic [3:0] n_waiting;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;

  // model: 0 = flight, 1 = waiting, 2 = ready
  int m_st [8];
  int m_rdy_at [8];
  int m_att [8];
  bit m_tied [8];
  bit m_ab [8];
  bit m_pend [8];
  bit m_valid, m_rab, m_rtied, m_perr;
  int m_id, m_last, m_nw;

  always #5 clk = ~clk;

  tsb_retry_sched dut (
    .clk(clk),
    .rstn(rstn),
    .cfg_base_delay(cfg_base_delay),
    .nack_valid(nack_valid),
    .nack_tsb_id(nack_tsb_id),
    .nack_tied(nack_tied),
    .ack_valid(ack_valid),
    .ack_tsb_id(ack_tsb_id),
    .abort_valid(abort_valid),
    .abort_tsb_id(abort_tsb_id),
    .retry_valid(retry_valid),
    .retry_ready(retry_ready),
    .retry_tsb_id(retry_tsb_id),
    .retry_abort(retry_abort),
    .retry_tied(retry_tied),
    .n_waiting(n_waiting),
    .empty(empty),
    .proto_err(proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d",
             tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_st[i] = 0;
      m_rdy_at[i] = 0;
      m_att[i] = 0;
      m_tied[i] = 0;
      m_ab[i] = 0;
      m_pend[i] = 0;
    end
    m_valid = 0;
    m_rab = 0;
    m_rtied = 0;
    m_perr = 0;
    m_id = 0;
    m_last = 7;
    m_nw = 0;
  endtask

  task automatic model_edge();
    int p_st [8];
    bit p_ab [8];
    bit p_tied [8];
    bit p_pend [8];
    int cntw, pk, idx, b;
    longint d;
    bit pv, hs, nk, ak, bk, held;
    cyc++;
    if (!rstn) begin
      model_reset();
      return;
    end
    cntw = 0;
    for (int i = 0; i < 8; i++) begin
      p_st[i] = m_st[i];
      p_ab[i] = m_ab[i];
      p_tied[i] = m_tied[i];
      p_pend[i] = m_pend[i];
      if (m_st[i] != 0) cntw++;
    end
    pv = m_valid;
    hs = m_valid && retry_ready;
    pk = -1;
    if (!pv || retry_ready)
      for (int pass = 0; pass < 2; pass++)
        for (int k = 1; k <= 8; k++) begin
          idx = (m_last + k) % 8;
          if (pk < 0 && p_st[idx] == 2 && !(pv && m_id == idx) &&
              p_ab[idx] == (pass == 0))
            pk = idx;
        end
    for (int i = 0; i < 8; i++) begin
      nk = nack_valid && int'(nack_tsb_id) == i;
      ak = ack_valid && int'(ack_tsb_id) == i;
      bk = abort_valid && int'(abort_tsb_id) == i;
      held = pv && m_id == i;
      if (p_st[i] == 0) begin
        if (nk) begin
          b = (cfg_base_delay == 0) ? 1 : int'(cfg_base_delay);
          d = longint'(b) << m_att[i];
          if (d > 65535) d = 65535;
          m_att[i] = (m_att[i] >= 6) ? 6 : m_att[i] + 1;
          m_tied[i] = nack_tied;
          if (p_pend[i] || bk) begin
            m_st[i] = 2;
            m_ab[i] = 1;
          end else begin
            m_st[i] = 1;
            m_rdy_at[i] = cyc + int'(d);
          end
        end else begin
          if (ak) begin
            m_att[i] = 0;
            m_pend[i] = 0;
          end
          if (bk) m_pend[i] = 1;
        end
      end else begin
        if (nk || ak) m_perr = 1;
        if (p_st[i] == 1) begin
          if (bk) begin
            m_st[i] = 2;
            m_ab[i] = 1;
          end
        end else if (held && hs) begin
          m_st[i] = 0;
          if (m_rab) begin
            m_att[i] = 0;
            m_pend[i] = 0;
          end else if (bk) m_pend[i] = 1;
        end else if (held) begin
          if (bk) m_pend[i] = 1;
        end else if (bk) begin
          m_ab[i] = 1;
          if (pk == i && pv) m_pend[i] = 1;
        end
      end
    end
    if (!pv || retry_ready) begin
      if (pk >= 0) begin
        m_valid = 1;
        m_id = pk;
        m_rab = p_ab[pk] | (abort_valid && int'(abort_tsb_id) == pk && !pv);
        m_rtied = p_tied[pk];
        m_last = pk;
      end else m_valid = 0;
    end
    for (int i = 0; i < 8; i++)
      if (m_st[i] == 1 && m_rdy_at[i] <= cyc) begin
        m_st[i] = 2;
        m_ab[i] = 0;
      end
    m_nw = cntw;
  endtask

  task automatic compare();
    chk("valid", retry_valid, m_valid);
    chk("n_waiting", n_waiting, m_nw);
    chk("empty", empty, (m_nw == 0 && !m_valid));
    chk("proto_err", proto_err, m_perr);
    if (m_valid) begin
      chk("tsb_id", retry_tsb_id, m_id);
      chk("abort", retry_abort, m_rab);
      chk("tied", retry_tied, m_rtied);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    nack_valid = 0;
    ack_valid = 0;
    abort_valid = 0;
  endtask

  task automatic nack(input int id, input bit t);
    nack_valid = 1;
    nack_tsb_id = 3'(id);
    nack_tied = t;
    tick();
  endtask

  task automatic ack(input int id);
    ack_valid = 1;
    ack_tsb_id = 3'(id);
    tick();
  endtask

  task automatic abort(input int id);
    abort_valid = 1;
    abort_tsb_id = 3'(id);
    tick();
  endtask

  task automatic wait_issue(input int bound, output int at);
    for (int k = 0; k < bound && retry_valid !== 1'b1; k++) tick();
    chk("issue_timeout", retry_valid, 1);
    at = cyc;
  endtask

  initial begin
    int t, at, exp_d;
    rstn = 0;
    cfg_base_delay = 8'd4;
    nack_valid = 0; nack_tsb_id = 0; nack_tied = 0;
    ack_valid = 0; ack_tsb_id = 0;
    abort_valid = 0; abort_tsb_id = 0;
    retry_ready = 1;
    tick();
    tick();
    chk("rst_id", retry_tsb_id, 0);
    chk("rst_abort", retry_abort, 0);
    chk("rst_tied", retry_tied, 0);
    chk("rst_empty", empty, 1);
    rstn = 1;
    tick();

    // basic retry latency
    nack(2, 1);
    t = cyc;
    wait_issue(20, at);
    chk("t1_latency", at - t, 5);
    chk("t1_id", retry_tsb_id, 2);
    chk("t1_abort", retry_abort, 0);
    chk("t1_tied", retry_tied, 1);
    tick();
    ack(2);

    // exponential backoff growth and saturation
    exp_d = 4;
    for (int n = 0; n < 9; n++) begin
      nack(1, 0);
      t = cyc;
      wait_issue(400, at);
      chk("t2_gap", at - t - 1, exp_d);
      tick();
      if (exp_d < 256) exp_d *= 2;
    end
    ack(1);
    nack(1, 0);
    t = cyc;
    wait_issue(20, at);
    chk("t2_gap_after_ack", at - t - 1, 4);
    tick();

    // abort cancels a long backoff
    cfg_base_delay = 8'd51;
    nack(3, 0);
    for (int k = 0; k < 5; k++) tick();
    abort(3);
    tick();
    chk("t3_valid", retry_valid, 1);
    chk("t3_id", retry_tsb_id, 3);
    chk("t3_abort", retry_abort, 1);
    tick();
    tick();
    chk("t3_nw", n_waiting, 0);
    cfg_base_delay = 8'd4;

    // abort while flight, then NACK
    abort(5);
    nack(5, 1);
    t = cyc;
    tick();
    chk("t4_fast", retry_valid, 1);
    chk("t4_id", retry_tsb_id, 5);
    chk("t4_abort", retry_abort, 1);
    tick();
    nack(5, 0);
    t = cyc;
    wait_issue(20, at);
    chk("t4_latency", at - t, 5);
    chk("t4_abort2", retry_abort, 0);
    tick();

    // simultaneous ready entries, stall then back-to-back
    nack(7, 0);
    wait_issue(20, at);
    tick();
    ack(7);
    retry_ready = 0;
    cfg_base_delay = 8'd6;
    nack(6, 0);
    cfg_base_delay = 8'd5;
    nack(4, 0);
    cfg_base_delay = 8'd4;
    nack(0, 0);
    wait_issue(20, at);
    chk("t5_first", retry_tsb_id, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_hold_valid", retry_valid, 1);
      chk("t5_hold_id", retry_tsb_id, 0);
    end
    retry_ready = 1;
    tick();
    chk("t5_second", retry_tsb_id, 4);
    tick();
    chk("t5_third", retry_tsb_id, 6);
    tick();
    chk("t5_drain", retry_valid, 0);

    // protocol error and mid-backoff reset
    nack(7, 1);
    nack(7, 1);
    chk("t6_perr", proto_err, 1);
    tick();
    chk("t6_sticky", proto_err, 1);
    rstn = 0;
    tick();
    chk("t6_valid", retry_valid, 0);
    chk("t6_id", retry_tsb_id, 0);
    chk("t6_abort", retry_abort, 0);
    chk("t6_tied", retry_tied, 0);
    chk("t6_perr_clr", proto_err, 0);
    chk("t6_nw", n_waiting, 0);
    chk("t6_empty", empty, 1);
    rstn = 1;
    tick();

    // random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      rstn = ($urandom_range(0, 499) != 0);
      cfg_base_delay = 8'($urandom_range(0, 5));
      retry_ready = ($urandom_range(0, 9) < 7);
      nack_valid = ($urandom_range(0, 2) == 0);
      nack_tsb_id = 3'($urandom_range(0, 7));
      nack_tied = 1'($urandom_range(0, 1));
      ack_valid = ($urandom_range(0, 3) == 0);
      ack_tsb_id = 3'($urandom_range(0, 7));
      if (nack_valid && ack_tsb_id == nack_tsb_id) ack_valid = 0;
      abort_valid = ($urandom_range(0, 7) == 0);
      abort_tsb_id = 3'($urandom_range(0, 7));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
